// File: rtl/dbus_access_ctrl_pkg.sv
// Shared data-bus types for the memory stage and its access controller.
package dbus_access_ctrl_pkg;

  typedef enum logic [2:0] {
    MSIZE1 = 3'd0,
    MSIZE2 = 3'd1,
    MSIZE4 = 3'd2,
    MSIZE8 = 3'd3
  } msize_t;

  typedef struct packed {
    logic        valid;
    logic [31:0] addr;
    msize_t      size;
    logic [3:0]  strobe;
    logic [31:0] data;
  } dbus_req_t;

  typedef struct packed {
    logic        addr_ok;
    logic        data_ok;
    logic [31:0] data;
  } dbus_resp_t;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    ADDR  = 3'd1,
    DATA  = 3'd2,
    HOLD  = 3'd3,
    DRAIN = 3'd4
  } dbus_ctrl_state_t;

endpackage

// File: rtl/dbus_watchdog.sv
// Access watchdog: counts wait cycles of one dbus access and raises a sticky flag.
// Only built when DBUS_TIMEOUT_EN is defined.
`ifdef DBUS_TIMEOUT_EN
module dbus_watchdog #(
  parameter int TIMEOUT_CYCLES = 1024
) (
  input  logic clk,
  input  logic reset,
  input  logic clear,
  input  logic count_en,
  output logic timeout
);

  localparam int CNT_W = $clog2(TIMEOUT_CYCLES) + 1;
  localparam logic [CNT_W-1:0] LIMIT = CNT_W'(TIMEOUT_CYCLES - 1);

  logic [CNT_W-1:0] cnt_r;
  logic [CNT_W-1:0] cnt_inc_s;
  logic             timeout_r;

  assign cnt_inc_s = cnt_r + {{(CNT_W-1){1'b0}}, 1'b1};

  // Counter saturates at the limit so it never wraps; the flag stays set until reset.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt_r     <= {CNT_W{1'b0}};
      timeout_r <= 1'b0;
    end else if (clear) begin
      cnt_r <= {CNT_W{1'b0}};
    end else if (count_en && (cnt_r != LIMIT)) begin
      cnt_r <= cnt_inc_s;
      if (cnt_inc_s == LIMIT) begin
        timeout_r <= 1'b1;
      end
    end
  end

  assign timeout = timeout_r;

endmodule
`endif

// File: rtl/dbus_access_ctrl.sv
// Memory-stage data-bus access sequencer: one outstanding access, stall until done.
// Optional watchdog enabled by defining DBUS_TIMEOUT_EN.
module dbus_access_ctrl
  import dbus_access_ctrl_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 1024
) (
  input  logic        clk,
  input  logic        reset,
  input  dbus_req_t   stage_req,
  input  logic        stage_advance,
  input  logic        flush,
  output dbus_req_t   dreq,
  input  dbus_resp_t  dresp,
  output logic        stall_mem,
  output logic [31:0] rdata,
  output logic        timeout
);

  dbus_ctrl_state_t state_r, state_next_s;
  dbus_req_t        req_r, req_next_s;
  logic [31:0]      rdata_r, rdata_next_s;
  logic             start_s;
  logic             start_ok_s;

  // Reset gates the pass-through so nothing reaches the bus while reset is held.
  assign start_ok_s = stage_req.valid && !flush && !reset;

  // State, latched request and captured read data.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_r <= IDLE;
      req_r   <= '0;
      rdata_r <= 32'h0000_0000;
    end else begin
      state_r <= state_next_s;
      req_r   <= req_next_s;
      rdata_r <= rdata_next_s;
    end
  end

  // Next state and bus/pipeline outputs.
  always_comb begin
    state_next_s = state_r;
    req_next_s   = req_r;
    rdata_next_s = rdata_r;
    dreq         = '0;
    stall_mem    = 1'b0;
    rdata        = rdata_r;
    start_s      = 1'b0;
    case (state_r)
      IDLE: begin
        if (start_ok_s) begin
          start_s = 1'b1;
          dreq    = stage_req;
          if (dresp.addr_ok && dresp.data_ok) begin
            state_next_s = HOLD;
            rdata_next_s = dresp.data;
            rdata        = dresp.data;
          end else if (dresp.addr_ok) begin
            state_next_s = DATA;
            stall_mem    = 1'b1;
          end else begin
            state_next_s = ADDR;
            req_next_s   = stage_req;
            stall_mem    = 1'b1;
          end
        end else begin
          state_next_s = IDLE;
        end
      end
      ADDR: begin
        dreq       = req_r;
        dreq.valid = 1'b1;
        stall_mem  = 1'b1;
        // Once addr_ok is seen the transaction exists and must run to data_ok.
        if (dresp.addr_ok && dresp.data_ok) begin
          if (flush) begin
            state_next_s = IDLE;
          end else begin
            state_next_s = HOLD;
            rdata_next_s = dresp.data;
          end
        end else if (dresp.addr_ok) begin
          state_next_s = flush ? DRAIN : DATA;
        end else if (flush) begin
          state_next_s = IDLE;
        end else begin
          state_next_s = ADDR;
        end
      end
      DATA: begin
        stall_mem = 1'b1;
        if (dresp.data_ok) begin
          if (flush) begin
            state_next_s = IDLE;
          end else begin
            state_next_s = HOLD;
            rdata_next_s = dresp.data;
          end
        end else if (flush) begin
          state_next_s = DRAIN;
        end else begin
          state_next_s = DATA;
        end
      end
      HOLD: begin
        // stage_req here still belongs to the finished instruction; the next one
        // is picked up from IDLE once the stage register has moved.
        if (flush || stage_advance) begin
          state_next_s = IDLE;
        end else begin
          state_next_s = HOLD;
        end
      end
      DRAIN: begin
        stall_mem = 1'b1;
        if (dresp.data_ok) begin
          state_next_s = IDLE;
        end else begin
          state_next_s = DRAIN;
        end
      end
      default: begin
        state_next_s = IDLE;
      end
    endcase
  end

`ifdef DBUS_TIMEOUT_EN
  logic count_en_s;

  assign count_en_s = (state_r == ADDR) || (state_r == DATA) || (state_r == DRAIN);

  dbus_watchdog #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) u_watchdog (
    .clk     (clk),
    .reset   (reset),
    .clear   (start_s),
    .count_en(count_en_s),
    .timeout (timeout)
  );
`else
  logic unused_wd_s;

  assign unused_wd_s = start_s & (TIMEOUT_CYCLES > 32'sd0);
  assign timeout     = 1'b0;
`endif

endmodule

// File: tb/tb_dbus_access_ctrl.sv
// Self-checking bench for dbus_access_ctrl: vector table, scoreboard and corner sequences.
module tb_dbus_access_ctrl;
  import dbus_access_ctrl_pkg::*;

  logic        clk = 1'b0;
  logic        reset;
  dbus_req_t   stage_req;
  logic        stage_advance;
  logic        flush;
  dbus_req_t   dreq;
  dbus_resp_t  dresp;
  logic        stall_mem;
  logic [31:0] rdata;
  logic        timeout;

  int          total = 0;
  int          bad = 0;
  int          accepts = 0;
  int          exp_accepts = 0;
  logic        outstanding = 1'b0;
  logic [31:0] exp_q[$];

  typedef struct {
    logic [31:0] addr;
    msize_t      size;
    logic [3:0]  strobe;
    int          aw;
    int          dw;
    logic [31:0] exp_rdata;
    int          exp_stall;
  } vec_t;

  vec_t vecs[6];

  always #5 clk = ~clk;

  dbus_access_ctrl #(.TIMEOUT_CYCLES(16)) dut (
    .clk          (clk),
    .reset        (reset),
    .stage_req    (stage_req),
    .stage_advance(stage_advance),
    .flush        (flush),
    .dreq         (dreq),
    .dresp        (dresp),
    .stall_mem    (stall_mem),
    .rdata        (rdata),
    .timeout      (timeout)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h at %0t", name, act, exp, $time);
    end
  endtask

  // Called once per cycle at the negedge: single-outstanding protocol check.
  task automatic bus_mon();
    if (outstanding) chk("no_overlap", {31'd0, dreq.valid}, 32'd0);
    if (dreq.valid && dresp.addr_ok) begin
      accepts++;
      outstanding = !dresp.data_ok;
    end else if (dresp.data_ok) begin
      outstanding = 1'b0;
    end
  endtask

  task automatic set_req(input logic v, input logic [31:0] a, input msize_t s, input logic [3:0] st);
    stage_req = '{valid: v, addr: a, size: s, strobe: st, data: ~a};
  endtask

  task automatic set_resp(input logic a_ok, input logic d_ok, input logic [31:0] d);
    dresp = '{addr_ok: a_ok, data_ok: d_ok, data: d};
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  // Two HOLD cycles (first without, then with stage_advance); checks captured data.
  task automatic hold_and_advance(input logic [31:0] exp_rd, input logic pop_now);
    set_resp(1'b0, 1'b0, $urandom);
    stage_advance = 1'b0;
    @(negedge clk);
    chk("hold_valid", {31'd0, dreq.valid}, 32'd0);
    chk("hold_stall", {31'd0, stall_mem}, 32'd0);
    if (pop_now) chk("sb_rdata", rdata, exp_q.pop_front());
    chk("hold_rdata", rdata, exp_rd);
    bus_mon();
    next_cycle();
    stage_advance = 1'b1;
    @(negedge clk);
    chk("adv_stall", {31'd0, stall_mem}, 32'd0);
    chk("adv_rdata", rdata, exp_rd);
    bus_mon();
    next_cycle();
    stage_advance = 1'b0;
  endtask

  initial begin
    int stalls;
    int last;
    logic [31:0] prev_rd;

    vecs[0] = '{32'h8000_0010, MSIZE4, 4'h0, 0, 0, 32'hDEAD_BEEF, 0};
    vecs[1] = '{32'h8000_0020, MSIZE4, 4'h0, 3, 1, 32'hCAFE_0001, 5};
    vecs[2] = '{32'h8000_0100, MSIZE4, 4'hF, 1, 2, 32'h0000_5A5A, 4};
    vecs[3] = '{32'h8000_0104, MSIZE4, 4'h0, 0, 3, 32'h1122_3344, 4};
    vecs[4] = '{32'h8000_0200, MSIZE2, 4'h0, 2, 0, 32'hA5A5_0F0F, 3};
    vecs[5] = '{32'h8000_0303, MSIZE1, 4'h8, 0, 1, 32'h7700_0000, 2};

    reset = 1'b1;
    flush = 1'b0;
    stage_advance = 1'b0;
    set_req(1'b1, 32'h8000_0000, MSIZE4, 4'h0);
    set_resp(1'b1, 1'b1, 32'hFFFF_FFFF);
    repeat (3) @(negedge clk);
    chk("rst_valid", {31'd0, dreq.valid}, 32'd0);
    chk("rst_stall", {31'd0, stall_mem}, 32'd0);
    chk("rst_rdata", rdata, 32'd0);
    chk("rst_timeout", {31'd0, timeout}, 32'd0);
    set_req(1'b0, 32'h0, MSIZE4, 4'h0);
    set_resp(1'b0, 1'b0, 32'h0);
    next_cycle();
    reset = 1'b0;
    next_cycle();

    // Table-driven accesses, back to back through HOLD.
    for (int n = 0; n < 6; n++) begin
      last = vecs[n].aw + vecs[n].dw;
      stalls = 0;
      exp_q.push_back(vecs[n].exp_rdata);
      exp_accepts++;
      for (int i = 0; i <= last; i++) begin
        if (i == 0) set_req(1'b1, vecs[n].addr, vecs[n].size, vecs[n].strobe);
        else stage_req.addr = $urandom;
        set_resp(i == vecs[n].aw, i == last, (i == last) ? vecs[n].exp_rdata : $urandom);
        @(negedge clk);
        chk("dreq_valid", {31'd0, dreq.valid}, {31'd0, (i <= vecs[n].aw)});
        if (i <= vecs[n].aw) begin
          chk("dreq_addr", dreq.addr, vecs[n].addr);
          chk("dreq_strobe", {28'd0, dreq.strobe}, {28'd0, vecs[n].strobe});
        end
        if (stall_mem) stalls++;
        if (last == 0) chk("sb_rdata_comb", rdata, exp_q.pop_front());
        bus_mon();
        next_cycle();
      end
      stage_req.addr = vecs[n].addr;
      chk("stall_cycles", stalls, vecs[n].exp_stall);
      hold_and_advance(vecs[n].exp_rdata, last != 0);
    end
    prev_rd = vecs[5].exp_rdata;

    // Flush while waiting in DATA: transaction drains, data discarded.
    exp_accepts++;
    set_req(1'b1, 32'h8000_0400, MSIZE4, 4'h0);
    set_resp(1'b1, 1'b0, 32'h0);
    @(negedge clk); chk("fd_c0_stall", {31'd0, stall_mem}, 32'd1); bus_mon(); next_cycle();
    set_req(1'b0, 32'h0, MSIZE4, 4'h0);
    set_resp(1'b0, 1'b0, 32'h0);
    flush = 1'b1;
    @(negedge clk); chk("fd_c1_stall", {31'd0, stall_mem}, 32'd1); bus_mon(); next_cycle();
    flush = 1'b0;
    @(negedge clk); chk("fd_c2_stall", {31'd0, stall_mem}, 32'd1); chk("fd_c2_rdata", rdata, prev_rd); bus_mon(); next_cycle();
    set_resp(1'b0, 1'b1, 32'h1234_5678);
    @(negedge clk); chk("fd_c3_stall", {31'd0, stall_mem}, 32'd1); chk("fd_c3_rdata", rdata, prev_rd); bus_mon(); next_cycle();
    set_resp(1'b0, 1'b0, 32'h0);
    @(negedge clk); chk("fd_c4_stall", {31'd0, stall_mem}, 32'd0); chk("fd_c4_rdata", rdata, prev_rd); bus_mon(); next_cycle();
    // A zero-wait access right after proves the controller is back in IDLE.
    exp_accepts++;
    set_req(1'b1, 32'h8000_0500, MSIZE4, 4'h0);
    set_resp(1'b1, 1'b1, 32'h0BAD_F00D);
    @(negedge clk); chk("fd_next_stall", {31'd0, stall_mem}, 32'd0); chk("fd_next_rdata", rdata, 32'h0BAD_F00D); bus_mon(); next_cycle();
    hold_and_advance(32'h0BAD_F00D, 1'b0);

    // Flush in ADDR before addr_ok: request withdrawn, nothing accepted.
    set_req(1'b1, 32'h8000_0600, MSIZE4, 4'h0);
    set_resp(1'b0, 1'b0, 32'h0);
    @(negedge clk); bus_mon(); next_cycle();
    flush = 1'b1;
    @(negedge clk); chk("fa_c1_valid", {31'd0, dreq.valid}, 32'd1); chk("fa_c1_addr", dreq.addr, 32'h8000_0600); bus_mon(); next_cycle();
    flush = 1'b0;
    set_req(1'b0, 32'h0, MSIZE4, 4'h0);
    @(negedge clk); chk("fa_c2_valid", {31'd0, dreq.valid}, 32'd0); chk("fa_c2_stall", {31'd0, stall_mem}, 32'd0); bus_mon(); next_cycle();
    chk("fa_accepts", accepts, exp_accepts);

    // Flush in IDLE: no request reaches the bus.
    set_req(1'b1, 32'h8000_0700, MSIZE4, 4'h0);
    flush = 1'b1;
    @(negedge clk); chk("fi_valid", {31'd0, dreq.valid}, 32'd0); chk("fi_stall", {31'd0, stall_mem}, 32'd0); bus_mon(); next_cycle();
    flush = 1'b0;

    // Silent bus: watchdog (when built in) fires 15 edges after issue and sticks.
    set_resp(1'b0, 1'b0, 32'h0);
    @(negedge clk); bus_mon(); next_cycle();
    for (int k = 1; k <= 20; k++) begin
      next_cycle();
      if (k == 14 || k == 15 || k == 20) begin
`ifdef DBUS_TIMEOUT_EN
        chk("timeout", {31'd0, timeout}, {31'd0, (k >= 15)});
`else
        chk("timeout_off", {31'd0, timeout}, 32'd0);
`endif
        chk("wait_stall", {31'd0, stall_mem}, 32'd1);
      end
    end

    // Asynchronous reset mid-wait, checked before the next clock edge.
    @(negedge clk);
    #2;
    reset = 1'b1;
    #1;
    chk("arst_valid", {31'd0, dreq.valid}, 32'd0);
    chk("arst_stall", {31'd0, stall_mem}, 32'd0);
    chk("arst_rdata", rdata, 32'd0);
    chk("arst_timeout", {31'd0, timeout}, 32'd0);
    outstanding = 1'b0;
    next_cycle();
    reset = 1'b0;
    set_req(1'b0, 32'h0, MSIZE4, 4'h0);
    next_cycle();

    chk("sb_empty", exp_q.size(), 32'd0);
    chk("accepts", accepts, exp_accepts);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
